// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: scans eight common-anode 7-segment digits showing one of
// three 32-bit sources (display word, executed-cycle count, stall-cycle count).
// The selected value is snapshotted once per frame so a frame never tears.
module seg7_scan_driver #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        CLR,
  input  logic [31:0] display,
  input  logic        cpu_tick,
  input  logic        stall,
  input  logic        halt,
  input  logic [1:0]  sel,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [2:0]    idx;
  logic [31:0]   cyc_cnt;
  logic [31:0]   stl_cnt;
  logic [31:0]   snap;
  logic [1:0]    sel_q;

  logic          scan_tick;
  logic          frame_start;
  logic          load;
  logic [2:0]    idx_next;
  logic [31:0]   src;
  logic [31:0]   snap_next;
  logic [31:0]   shifted;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic          dp;

  assign scan_tick   = (prescaler == PRE_LAST);
  assign idx_next    = scan_tick ? idx + 3'd1 : idx;
  assign frame_start = scan_tick && (idx == 3'd7);
  // A select change reloads right away; otherwise reload only at frame start.
  assign load        = frame_start || (sel != sel_q);

  // Source mux and next snapshot, so digit 0 sees a frame-start load at once
  always_comb begin
    src = display;
    case (sel)
      2'd1:    src = cyc_cnt;
      2'd2:    src = stl_cnt;
      default: src = display;
    endcase
    snap_next = load ? src : snap;
  end

  // Pick the nibble for the digit about to be driven and decode to {g..a}
  always_comb begin
    shifted = snap_next >> {idx_next, 2'b00};
    nib     = shifted[3:0];
    glyph   = 7'h7F;
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
    // Decimal point on the rightmost digit flags a halted CPU
    dp = !(halt && (idx_next == 3'd0));
  end

  // Prescaler and digit index: one digit slot every SCAN_DIV clocks
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      prescaler <= '0;
      idx       <= 3'd0;
    end else begin
      prescaler <= scan_tick ? '0 : prescaler + 1'b1;
      idx       <= idx_next;
    end
  end

  // Saturating executed-cycle and stall-cycle counters, frozen while halted
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      cyc_cnt <= 32'd0;
      stl_cnt <= 32'd0;
    end else begin
      if (cpu_tick && !halt && (cyc_cnt != 32'hFFFF_FFFF))
        cyc_cnt <= cyc_cnt + 32'd1;
      if (cpu_tick && stall && !halt && (stl_cnt != 32'hFFFF_FFFF))
        stl_cnt <= stl_cnt + 32'd1;
    end
  end

  // Snapshot register and select history
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      snap  <= 32'd0;
      sel_q <= 2'd0;
    end else begin
      snap  <= snap_next;
      sel_q <= sel;
    end
  end

  // Registered digit enable and segment outputs, blank out of reset
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      an  <= 8'hFF;
      seg <= 8'hFF;
    end else if (scan_tick) begin
      an  <= ~(8'h01 << idx_next);
      seg <= {dp, glyph};
    end
  end

endmodule
